bsr_seg_chain: RTL and testbench

//  Parametrised boundary-scan chain of NSEG equal-width segments that wraps core I/O buses.
//  A JTAG-writable config register bypasses any segment, cutting it to a 1-bit stage.

---
 rtl/jtag_pkg.sv | 24 ++
 rtl/bsr_seg.sv | 55 +++++
 rtl/bsr_seg_chain.sv | 85 ++++++++
 tb/tb_bsr_seg_chain.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for JTAG data-register blocks: config reset value and
// the capture/shift/update priority resolution used by every DR.
package jtag_pkg;

   localparam logic CFG_RST_BIT = 1'b1;

   typedef enum logic [1:0] {
      DR_HOLD,
      DR_CAPTURE,
      DR_SHIFT,
      DR_UPDATE
   } dr_op_e;

   // Capture beats shift beats update; the losers are ignored for the cycle.
   function automatic dr_op_e dr_op_sel(input logic capture,
                                        input logic shift,
                                        input logic update);
      if (capture)     return DR_CAPTURE;
      else if (shift)  return DR_SHIFT;
      else if (update) return DR_UPDATE;
      else             return DR_HOLD;
   endfunction

endpackage

// File: rtl/bsr_seg.sv
// One boundary-scan segment: SEG_W-bit shift/update register, or a single
// bypass flop when the segment is disabled.
module bsr_seg
   import jtag_pkg::*;
#(
   parameter int unsigned SEG_W = 32
) (
   input  logic             tck,
   input  logic             trst,
   input  logic             en,
   input  logic             capture,
   input  logic             shift,
   input  logic             update,
   input  logic             mode,
   input  logic             si,
   output logic             so,
   input  logic [SEG_W-1:0] pin,
   output logic [SEG_W-1:0] pout
);

   logic [SEG_W-1:0] sr;
   logic [SEG_W-1:0] upd;
   logic             byp;
   dr_op_e           op;

   assign op = dr_op_sel(capture, shift, update);

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         sr  <= '0;
         upd <= '0;
         byp <= 1'b0;
      end else begin
         unique case (op)
            DR_CAPTURE: begin
               if (en) sr  <= pin;
               else    byp <= 1'b0;
            end
            DR_SHIFT: begin
               // si enters at the MSB; the cast keeps this legal for SEG_W == 1
               if (en) sr  <= SEG_W'({si, sr} >> 1);
               else    byp <= si;
            end
            DR_UPDATE: begin
               if (en) upd <= sr;
            end
            DR_HOLD: ;
         endcase
      end
   end

   assign so   = en ? sr[0] : byp;
   assign pout = (mode && en) ? upd : pin;

endmodule

// File: rtl/bsr_seg_chain.sv
// Boundary-scan chain of NSEG segments with a JTAG-writable config register
// that cuts any segment down to a 1-bit bypass stage.
module bsr_seg_chain
   import jtag_pkg::*;
#(
   parameter  int unsigned NSEG  = 6,
   parameter  int unsigned SEG_W = 32,
   localparam int unsigned LEN_W = $clog2(NSEG*SEG_W+1)
) (
   input  logic                  tck,
   input  logic                  trst,
   input  logic                  tdi,
   output logic                  tdo,
   input  logic                  sel_cfg,
   input  logic                  capture_dr,
   input  logic                  shift_dr,
   input  logic                  update_dr,
   input  logic                  mode,
   input  logic [NSEG*SEG_W-1:0] parallel_in,
   output logic [NSEG*SEG_W-1:0] parallel_out,
   output logic [LEN_W-1:0]      chain_len
);

   logic [NSEG-1:0] cfg_shift;
   logic [NSEG-1:0] cfg_active;
   logic [NSEG:0]   link;
   dr_op_e          cfg_op;
   logic            seg_capture;
   logic            seg_shift;
   logic            seg_update;
   int unsigned     n_en;

   assign cfg_op = dr_op_sel(capture_dr & sel_cfg,
                             shift_dr   & sel_cfg,
                             update_dr  & sel_cfg);

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         cfg_shift  <= {NSEG{CFG_RST_BIT}};
         cfg_active <= {NSEG{CFG_RST_BIT}};
      end else begin
         unique case (cfg_op)
            DR_CAPTURE: cfg_shift  <= cfg_active;
            DR_SHIFT:   cfg_shift  <= NSEG'({tdi, cfg_shift} >> 1);
            DR_UPDATE:  cfg_active <= cfg_shift;
            DR_HOLD:    ;
         endcase
      end
   end

   // The data chain only moves while the config register is deselected.
   assign seg_capture = capture_dr & ~sel_cfg;
   assign seg_shift   = shift_dr   & ~sel_cfg;
   assign seg_update  = update_dr  & ~sel_cfg;

   assign link[0] = tdi;

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      bsr_seg #(.SEG_W(SEG_W)) u_seg (
         .tck     (tck),
         .trst    (trst),
         .en      (cfg_active[k]),
         .capture (seg_capture),
         .shift   (seg_shift),
         .update  (seg_update),
         .mode    (mode),
         .si      (link[k]),
         .so      (link[k+1]),
         .pin     (parallel_in[k*SEG_W +: SEG_W]),
         .pout    (parallel_out[k*SEG_W +: SEG_W])
      );
   end

   assign tdo = sel_cfg ? cfg_shift[0] : link[NSEG];

   always_comb begin
      n_en = 0;
      for (int unsigned k = 0; k < NSEG; k++) begin
         if (cfg_active[k]) n_en = n_en + 1;
      end
   end

   assign chain_len = LEN_W'(SEG_W*n_en + (NSEG - n_en));

endmodule

// File: tb/tb_bsr_seg_chain.sv
// Directed and random bench for bsr_seg_chain against a queue-based model
// of the scan chain.
module tb_bsr_seg_chain;

   localparam int NSEG  = 6;
   localparam int SEG_W = 32;
   localparam int W     = NSEG*SEG_W;

   logic         tck = 1'b0;
   logic         trst, tdi, tdo, sel_cfg, capture_dr, shift_dr, update_dr, mode;
   logic [W-1:0] parallel_in, parallel_out;
   logic [7:0]   chain_len;

   bsr_seg_chain #(.NSEG(NSEG), .SEG_W(SEG_W)) dut (
      .tck          (tck),
      .trst         (trst),
      .tdi          (tdi),
      .tdo          (tdo),
      .sel_cfg      (sel_cfg),
      .capture_dr   (capture_dr),
      .shift_dr     (shift_dr),
      .update_dr    (update_dr),
      .mode         (mode),
      .parallel_in  (parallel_in),
      .parallel_out (parallel_out),
      .chain_len    (chain_len)
   );

   always #5 tck = ~tck;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [31:0]     m_sr  [NSEG];
   logic [31:0]     m_upd [NSEG];
   bit              m_byp [NSEG];
   logic [NSEG-1:0] m_act;
   logic [NSEG-1:0] m_cfg_sh;
   bit              chain_q [$];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NSEG; k++) begin
         m_sr[k] = '0; m_upd[k] = '0; m_byp[k] = 1'b0;
      end
      m_act    = '1;
      m_cfg_sh = '1;
   endfunction

   // Chain as a flat bit list, element 0 next to tdo.
   function automatic void build_chain();
      chain_q.delete();
      for (int k = NSEG-1; k >= 0; k--) begin
         if (m_act[k]) for (int b = 0; b < SEG_W; b++) chain_q.push_back(m_sr[k][b]);
         else          chain_q.push_back(m_byp[k]);
      end
   endfunction

   function automatic void scatter_chain();
      for (int k = NSEG-1; k >= 0; k--) begin
         if (m_act[k]) for (int b = 0; b < SEG_W; b++) m_sr[k][b] = chain_q.pop_front();
         else          m_byp[k] = chain_q.pop_front();
      end
   endfunction

   function automatic void model_edge(bit cap, bit sh, bit up, bit sel, bit t);
      if (cap) begin
         if (sel) m_cfg_sh = m_act;
         else for (int k = 0; k < NSEG; k++) begin
            if (m_act[k]) m_sr[k] = parallel_in[k*SEG_W +: SEG_W];
            else          m_byp[k] = 1'b0;
         end
      end else if (sh) begin
         if (sel) m_cfg_sh = (m_cfg_sh >> 1) | (NSEG'(t) << (NSEG-1));
         else begin
            build_chain();
            void'(chain_q.pop_front());
            chain_q.push_back(t);
            scatter_chain();
         end
      end else if (up) begin
         if (sel) m_act = m_cfg_sh;
         else for (int k = 0; k < NSEG; k++) if (m_act[k]) m_upd[k] = m_sr[k];
      end
   endfunction

   task automatic check_outputs();
      logic [W-1:0] ep;
      build_chain();
      check("tdo", W'(tdo), W'(sel_cfg ? m_cfg_sh[0] : chain_q[0]));
      check("chain_len", W'(chain_len), W'(chain_q.size()));
      for (int k = 0; k < NSEG; k++)
         ep[k*SEG_W +: SEG_W] = (mode && m_act[k]) ? m_upd[k] : parallel_in[k*SEG_W +: SEG_W];
      check("parallel_out", parallel_out, ep);
   endtask

   task automatic step(input bit cap, input bit sh, input bit up, input bit sel, input bit t);
      capture_dr = cap; shift_dr = sh; update_dr = up; sel_cfg = sel; tdi = t;
      model_edge(cap, sh, up, sel, t);
      @(posedge tck); #1;
      check_outputs();
   endtask

   task automatic apply_reset();
      logic saved_mode;
      saved_mode = mode;
      capture_dr = 0; shift_dr = 0; update_dr = 0; sel_cfg = 0;
      trst = 1'b0; mode = 1'b1;
      #1;
      model_reset();
      check("rst_tdo", W'(tdo), W'(0));
      check("rst_len", W'(chain_len), W'(192));
      check("rst_pout_mode1", parallel_out, '0);
      #1 trst = 1'b1;
      mode = saved_mode;
   endtask

   task automatic read_cfg(output logic [NSEG-1:0] v);
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < NSEG; i++) begin
         v[i] = tdo;
         step(0, 1, 0, 1, 1);
      end
   endtask

   task automatic load_cfg(input logic [NSEG-1:0] v);
      for (int i = 0; i < NSEG; i++) step(0, 1, 0, 1, v[i]);
      step(0, 0, 1, 1, 0);
   endtask

   task automatic shift_out(output logic [W-1:0] got);
      for (int i = 0; i < W; i++) begin
         got[i] = tdo;
         step(0, 1, 0, 0, 0);
      end
   endtask

   task automatic rand_pin();
      for (int k = 0; k < NSEG; k++) parallel_in[k*SEG_W +: SEG_W] = $urandom;
   endtask

   initial begin
      logic [NSEG-1:0] cfg_rd;
      logic [W-1:0]    got, exp, pin_saved;
      logic [31:0]     word;
      int              n;

      trst = 1'b0; tdi = 0; sel_cfg = 0; capture_dr = 0; shift_dr = 0;
      update_dr = 0; mode = 0; parallel_in = '0;
      model_reset();
      repeat (2) @(posedge tck);
      #1;
      check("init_len", W'(chain_len), W'(192));
      check("init_tdo", W'(tdo), W'(0));
      check("init_pout_mode0", parallel_out, parallel_in);
      trst = 1'b1;

      // Reset in the middle of random traffic
      rand_pin();
      for (int i = 0; i < 20; i++) step($urandom_range(0, 5) == 0, 1, $urandom_range(0, 5) == 0, 0, $urandom_range(0, 1));
      apply_reset();
      read_cfg(cfg_rd);
      check("cfg_readback_rst", W'(cfg_rd), W'(6'b111111));

      // Capture then full shift-out
      parallel_in = '0;
      parallel_in[31:0] = 32'hDEADBEEF;
      step(1, 0, 0, 0, 0);
      shift_out(got);
      check("capture_shift_out", got, {32'hDEADBEEF, 160'b0});

      // Bypass all but segment 0
      load_cfg(6'b000001);
      check("bypass_len", W'(chain_len), W'(37));
      repeat (40) step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 1);
      n = 1;
      while (tdo !== 1'b1 && n < 100) begin
         step(0, 1, 0, 0, 0);
         n++;
      end
      check("bypass_latency", W'(n), W'(37));

      // Update and mode
      load_cfg(6'b111111);
      word = 32'h12345678;
      for (int i = 0; i < 32; i++) step(0, 1, 0, 0, word[i]);
      repeat (160) step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      mode = 1'b1;
      #1;
      check("upd_slice5", W'(parallel_out[191:160]), W'(32'h12345678));
      check("upd_slices0_4", W'(parallel_out[159:0]), W'(0));
      rand_pin();
      load_cfg(6'b111110);
      check("bypassed_transparent", W'(parallel_out[31:0]), W'(parallel_in[31:0]));
      check("retained_slice5", W'(parallel_out[191:160]), W'(32'h12345678));

      // Reset mid-shift
      load_cfg(6'b000000);
      check("all_bypass_len", W'(chain_len), W'(6));
      load_cfg(6'b111111);
      mode = 1'b0;
      repeat (10) step(0, 1, 0, 0, 1);
      apply_reset();
      read_cfg(cfg_rd);
      check("cfg_readback_midshift", W'(cfg_rd), W'(6'b111111));

      // Overlapping capture and shift: capture wins
      rand_pin();
      pin_saved = parallel_in;
      step(1, 1, 0, 0, 1);
      shift_out(got);
      for (int k = 0; k < NSEG; k++) exp[(NSEG-1-k)*SEG_W +: SEG_W] = pin_saved[k*SEG_W +: SEG_W];
      check("overlap_capture", got, exp);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) rand_pin();
         if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1);
         step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
